// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types for the dual-issue data-memory arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int CNT_W      = 16;
  localparam int REQ_ADDR_W = 32;
  // The pending buffer carries store data at this width; DATA_W must not exceed it.
  localparam int REQ_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SERVE_L1 = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_L0   = 2'd0,
    SEL_L1   = 2'd1,
    SEL_PEND = 2'd2
  } req_sel_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_req_mux.sv
// ============================================================================
// dmem_req_mux : picks the memory-port driver (lane0, lane1 or pending buffer)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_req_mux
  import dmem_arb_pkg::*;
(
  input  req_sel_t sel,
  input  mem_req_t lane0,
  input  mem_req_t lane1,
  input  mem_req_t pend,
  output mem_req_t req_out
);

  always_comb begin
    req_out = lane0;
    case (sel)
      SEL_L1:   req_out = lane1;
      SEL_PEND: req_out = pend;
      default:  req_out = lane0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_dual_issue_arbiter.sv
// ============================================================================
// dmem_dual_issue_arbiter : serializes same-bundle lane0/lane1 dmem accesses
// Optional conflict counter built when DMEM_ARB_STATS_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_dual_issue_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              l0_req,
  input  logic              l1_req,
  input  logic              l0_we,
  input  logic              l1_we,
  input  logic [31:0]       l0_addr,
  input  logic [31:0]       l1_addr,
  input  logic [DATA_W-1:0] l0_wdata,
  input  logic [DATA_W-1:0] l1_wdata,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] l0_rdata,
  output logic [DATA_W-1:0] l1_rdata,
  output logic              stall,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  mem_req_t          r_pend;
  logic [DATA_W-1:0] r_l0_hold;
  mem_req_t          w_l0;
  mem_req_t          w_l1;
  mem_req_t          w_port;
  req_sel_t          w_sel;
  logic              w_conflict;
  logic              w_enter_serve;
  logic              w_port_en;
  logic              w_stall;
  logic              w_unused;

  assign w_l0 = '{we: l0_we, addr: l0_addr, wdata: REQ_DATA_W'(l0_wdata)};
  assign w_l1 = '{we: l1_we, addr: l1_addr, wdata: REQ_DATA_W'(l1_wdata)};

  assign w_conflict    = l0_req & l1_req;
  assign w_enter_serve = (r_state == IDLE) & w_conflict;

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = SEL_L0;
    w_port_en   = 1'b0;
    w_stall     = 1'b0;
    l0_rdata    = mem_rdata;
    l1_rdata    = mem_rdata;
    case (r_state)
      IDLE: begin
        w_port_en = l0_req | l1_req;
        if (!l0_req && l1_req)
          w_sel = SEL_L1;
        if (w_conflict) begin
          w_stall     = 1'b1;
          w_state_nxt = SERVE_L1;
        end
      end
      SERVE_L1: begin
        // Live lane inputs are ignored; flush squashes the younger access.
        w_sel       = SEL_PEND;
        w_port_en   = ~flush;
        l0_rdata    = r_l0_hold;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  dmem_req_mux u_req_mux (
    .sel     (w_sel),
    .lane0   (w_l0),
    .lane1   (w_l1),
    .pend    (r_pend),
    .req_out (w_port)
  );

  // Reset state is IDLE, but lane requests could still be live: keep the port quiet.
  assign mem_en    = w_port_en & reset_n;
  assign mem_we    = mem_en & w_port.we;
  assign mem_addr  = w_port.addr[ADDR_W+1:2];
  assign mem_wdata = DATA_W'(w_port.wdata);
  assign stall     = w_stall & reset_n;

  assign w_unused = &{1'b0, w_port.addr[REQ_ADDR_W-1:ADDR_W+2], w_port.addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      r_l0_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter_serve) begin
        r_pend    <= w_l1;
        r_l0_hold <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_conflict_cnt <= '0;
    else if (w_enter_serve && (r_conflict_cnt != {CNT_W{1'b1}}))
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_dual_issue_arbiter.sv
// ============================================================================
// tb_dmem_dual_issue_arbiter : directed bench with bundle-level memory model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dmem_dual_issue_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
`ifdef DMEM_ARB_STATS_EN
  localparam int EXP3 = 3;
`else
  localparam int EXP3 = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              l0_req, l1_req, l0_we, l1_we, flush;
  logic [31:0]       l0_addr, l1_addr;
  logic [DATA_W-1:0] l0_wdata, l1_wdata;
  logic              mem_en, mem_we, stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, l0_rdata, l1_rdata;
  logic [15:0]       conflict_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_dual_issue_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .l0_req(l0_req), .l1_req(l1_req), .l0_we(l0_we), .l1_we(l1_we),
    .l0_addr(l0_addr), .l1_addr(l1_addr), .l0_wdata(l0_wdata), .l1_wdata(l1_wdata),
    .flush(flush), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .l0_rdata(l0_rdata),
    .l1_rdata(l1_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  // Data memory with asynchronous read.
  logic [DATA_W-1:0] env_mem [0:255];
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;

  // Program-order reference memory and expected per-cycle outputs.
  logic [DATA_W-1:0] ref_mem [0:255];
  int          n_conf;
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_en, exp_we;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata, exp_l0, exp_l1;
  logic [15:0] exp_cnt;

  logic        obs_stall [0:1];
  logic        obs_en    [0:1];
  logic        obs_we    [0:1];
  logic [7:0]  obs_addr  [0:1];
  logic [31:0] obs_l0    [0:1];
  logic [31:0] obs_l1    [0:1];
  logic [15:0] obs_cnt   [0:1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int cnt_inc(input int c);
`ifdef DMEM_ARB_STATS_EN
    return (c == 65535) ? c : c + 1;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall",        32'(stall),        32'(exp_stall));
      chk("mem_en",       32'(mem_en),       32'(exp_en));
      chk("mem_we",       32'(mem_we),       32'(exp_we));
      chk("mem_addr",     32'(mem_addr),     32'(exp_addr));
      chk("l0_rdata",     32'(l0_rdata),     exp_l0);
      chk("l1_rdata",     32'(l1_rdata),     exp_l1);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      if (exp_we) chk("mem_wdata", 32'(mem_wdata), exp_wdata);
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic fl);
    l0_req = r0; l0_we = w0; l0_addr = a0; l0_wdata = d0;
    l1_req = r1; l1_we = w1; l1_addr = a1; l1_wdata = d1;
    flush = fl;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
    exp_addr  = l0_addr[9:2];
    exp_l0    = ref_mem[l0_addr[9:2]];
    exp_l1    = ref_mem[l0_addr[9:2]];
    exp_cnt   = 16'(n_conf);
    exp_valid = 1'b1;
  endtask

  task automatic capture(input int k);
    @(negedge clk); #1;
    obs_stall[k] = stall; obs_en[k] = mem_en; obs_we[k] = mem_we; obs_addr[k] = mem_addr;
    obs_l0[k] = l0_rdata; obs_l1[k] = l1_rdata; obs_cnt[k] = conflict_cnt;
  endtask

  // One issue bundle; a conflicting bundle occupies two cycles.
  task automatic bundle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic fl, input logic rst_in_serve);
    logic [7:0]  wa0, wa1, wsel;
    logic [31:0] hold;
    wa0 = a0[9:2];
    wa1 = a1[9:2];
    @(posedge clk); #1;
    drive(r0, w0, a0, d0, r1, w1, a1, d1, 1'b0);
    if (r0 && r1) begin
      exp_stall = 1'b1; exp_en = 1'b1; exp_we = w0; exp_addr = wa0; exp_wdata = d0;
      exp_l0 = ref_mem[wa0]; exp_l1 = ref_mem[wa0]; exp_cnt = 16'(n_conf); exp_valid = 1'b1;
      hold = ref_mem[wa0];
      if (w0) ref_mem[wa0] = d0;
      n_conf = cnt_inc(n_conf);
      capture(0);
      @(posedge clk); #1;
      // Unrelated live traffic during the second cycle must not reach memory.
      drive(1'b1, 1'b1, 32'h3FC, 32'hDEAD, 1'b1, 1'b1, 32'h3F8, 32'hBEEF, fl);
      exp_stall = 1'b0; exp_en = !fl; exp_we = w1 && !fl; exp_addr = wa1; exp_wdata = d1;
      exp_l0 = hold; exp_l1 = ref_mem[wa1]; exp_cnt = 16'(n_conf);
      capture(1);
      if (rst_in_serve) begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        n_conf = 0;
        set_idle_exp();
      end else if (w1 && !fl) begin
        ref_mem[wa1] = d1;
      end
    end else begin
      wsel = (!r0 && r1) ? wa1 : wa0;
      exp_stall = 1'b0; exp_en = r0 | r1; exp_we = r0 ? w0 : (r1 & w1); exp_addr = wsel;
      exp_wdata = (!r0 && r1) ? d1 : d0;
      exp_l0 = ref_mem[wsel]; exp_l1 = ref_mem[wsel]; exp_cnt = 16'(n_conf); exp_valid = 1'b1;
      capture(0);
      if (exp_we) ref_mem[wsel] = exp_wdata;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_conf = 0;
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'(i + 100);
      ref_mem[i] = 32'(i + 100);
    end
    env_mem[2] = 32'd5; ref_mem[2] = 32'd5;
    env_mem[3] = 32'd8; ref_mem[3] = 32'd8;
    n_conf  = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_idle_exp();

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_l0_rdata", l0_rdata, 32'd100);
    chk("rst_l1_rdata", l1_rdata, 32'd100);
    @(posedge clk); #1 reset_n = 1'b1;

    // Both lanes load: lane0 mem[2], lane1 mem[3]
    bundle(1'b1, 1'b0, 32'h08, 32'h0, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0);
    chk("dual_ld_stall_n", 32'(obs_stall[0]), 32'd1);
    chk("dual_ld_addr_n", 32'(obs_addr[0]), 32'd2);
    chk("dual_ld_addr_n1", 32'(obs_addr[1]), 32'd3);
    chk("dual_ld_l0", obs_l0[1], 32'd5);
    chk("dual_ld_l1", obs_l1[1], 32'd8);
    chk("dual_ld_stall_n1", 32'(obs_stall[1]), 32'd0);

    // Lane0-only store 13 @ 0x08, then load it back
    bundle(1'b1, 1'b1, 32'h08, 32'd13, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("l0_st_we", 32'(obs_we[0]), 32'd1);
    chk("l0_st_addr", 32'(obs_addr[0]), 32'd2);
    chk("l0_st_stall", 32'(obs_stall[0]), 32'd0);
    bundle(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("l0_ld_data", obs_l0[0], 32'd13);
    chk("l0_ld_stall", 32'(obs_stall[0]), 32'd0);

    // Lane0 store then lane1 load, same address
    bundle(1'b1, 1'b1, 32'h10, 32'd21, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    chk("raw_l1_data", obs_l1[1], 32'd21);

    // Two stores to the same word: lane1 wins
    bundle(1'b1, 1'b1, 32'h0C, 32'd1, 1'b1, 1'b1, 32'h0C, 32'd2, 1'b0, 1'b0);
    bundle(1'b0, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("waw_mem3", env_mem[3], 32'd2);

    // Flush during the second cycle drops the lane1 store
    bundle(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h14, 32'd99, 1'b1, 1'b0);
    chk("flush_mem_en", 32'(obs_en[1]), 32'd0);
    bundle(1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_mem5", env_mem[5], 32'd105);

    // Three back-to-back conflicts, reset during the last second cycle
    do_reset();
    bundle(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0);
    bundle(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0);
    bundle(1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h18, 32'd77, 1'b0, 1'b1);
    chk("cnt_before_rst", 32'(obs_cnt[1]), 32'(EXP3));
    @(negedge clk); #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_idle_exp();
    bundle(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("midrst_l0_data", obs_l0[0], 32'd106);
    chk("midrst_mem6", env_mem[6], 32'd106);
    chk("post_rst_stall", 32'(obs_stall[0]), 32'd0);

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
